link_round_robin_scheduler: RTL and testbench
=============================================

// Module: link_round_robin_scheduler
// PURPOSE
// - Shares one 64-bit repair/serialise datapath among NUM_CH detector link requesters.
// - Round-robin arbitration in bursts; one registered output word stage feeding the datapath.
// - Tags each word with its source channel and a first-of-burst flag, so the datapath can clear its 3-word window.
// - Sits between the link deserialisers and the data-processing block.
// PARAMETERS
// NUM_CH    4   number of requesting links (2..8)
// DATA_W    64  word width
// CH_W      2   channel-id width, = $clog2(NUM_CH)
// PORTS
// clk           in   1             clock, all logic on rising edge
// reset         in   1             asynchronous, active-high
// req_valid     in   NUM_CH        per-channel word available
// req_data      in   NUM_CH*DATA_W channel c at [c*DATA_W +: DATA_W]
// req_ready     out  NUM_CH        per-channel word accepted this cycle (one-hot or zero)
// cfg_ch_en     in   NUM_CH        channel enable mask
// cfg_burst     in   4             max words per grant; 0 is treated as 1
// proc_valid    out  1             output word valid
// proc_data     out  DATA_W        output word
// proc_ch       out  CH_W          source channel of proc_data
// proc_first    out  1             first word of a burst
// proc_taken    in   1             datapath accepts word (transfer = proc_valid & proc_taken)
// grant_ch      out  CH_W          currently/last granted channel
// busy          out  1             FSM in GRANT
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, burst_cnt=0. All outputs 0, including proc_*, grant_ch, busy and req_ready. The held output word is discarded.
// - States:
//   - IDLE: candidates = req_valid & cfg_ch_en. Search starts at rr_ptr, upward, wrapping mod NUM_CH.
//     - First hit g: grant_ch<=g, burst_cnt<=0, -> GRANT.
//     - No hit: stay in IDLE.
//   - GRANT: out_free = !proc_valid | proc_taken.
//     - req_ready[grant_ch] = out_free & req_valid[grant_ch] & cfg_ch_en[grant_ch]. This is combinational from proc_taken.
//     - Accept: proc_data/proc_ch <= word/grant_ch, proc_valid<=1, proc_first<=(burst_cnt==0), burst_cnt++.
//     - Burst ends -> IDLE, rr_ptr <= grant_ch+1 mod NUM_CH. Ends on any of:
//       - the accepted word is number max(cfg_burst,1);
//       - out_free high while req_valid[grant_ch]=0;
//       - cfg_ch_en[grant_ch] dropped.
//     - out_free low: hold everything, no accept.
// - Output reg: proc_taken with no new accept -> proc_valid<=0. Data is stable while proc_valid & !proc_taken.
// - Latency: word accepted at edge N is visible at N+1. IDLE->GRANT costs one cycle, i.e. one bubble per channel switch.
// - Throughput: 1 word/cycle inside a burst when proc_taken is held high.
// - Simultaneous proc_taken and accept: back-to-back, no bubble.
// - Channel order is preserved per channel; never more than one req_ready high.
// - cfg_* sampled every cycle. Changes mid-burst take effect next accept; a changed cfg_burst below burst_cnt ends the burst at next accept.
// - Reset mid-burst: an unaccepted word is not lost (req_ready was low); the in-flight output word is dropped.
// CONFIGURATION
// - GRANT_STATS_EN defined: per-channel 16-bit saturating counter of transferred words (proc_valid & proc_taken, indexed by proc_ch).
//   - Extra ports: stat_sel (in, CH_W) and stat_cnt (out, 16), combinational read.
//   - Counters clear on reset.
// - Not defined: no counters, no stat ports; behaviour otherwise identical.
// TESTING
// - Single channel: ch1 offers 0x11..01,0x22..02,0x33..03, cfg_burst=4, proc_taken=1 -> words in order, proc_ch=1, proc_first only on 0x11..01, 1-cycle latency.
// - All four channels valid, cfg_burst=2 -> grants 0,1,2,3,0; 2 words each; one bubble at each switch.
// - Backpressure: proc_taken=0 for 5 cycles mid-burst -> proc_data stable, req_ready=0, no word lost or duplicated.
// - cfg_ch_en=4'b1010, all valid -> only ch1, ch3 granted, alternating; cfg_burst=0 -> bursts of 1.
// - Reset asserted mid-burst -> outputs 0 next edge; after release ch with rr_ptr=0 search restarts at ch0.
// - GRANT_STATS_EN: 10 words from ch2 with 3 stalls -> stat_sel=2 reads 10; others 0.

Source files
------------

// File: rtl/link_round_robin_scheduler.sv
// -----------------------------------------------------------------------------
// link_round_robin_scheduler
//
// Shares one 64-bit repair/serialise datapath among NUM_CH detector link
// requesters. Channels are granted round-robin in bursts of up to cfg_burst
// words (0 behaves as 1). Accepted words pass through a single registered
// output stage. Each word is tagged with its source channel and a
// first-of-burst flag so that the datapath can clear its 3-word window.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        asynchronous, active-high
//   req_valid    per-channel word available
//   req_data     per-channel words; channel c at [c*DATA_W +: DATA_W]
//   req_ready    per-channel accept strobe (one-hot or zero), combinational
//   cfg_ch_en    channel enable mask
//   cfg_burst    max words per grant; 0 is treated as 1
//   proc_valid   output word valid
//   proc_data    output word
//   proc_ch      source channel of proc_data
//   proc_first   first word of a burst
//   proc_taken   datapath accepts word (transfer = proc_valid & proc_taken)
//   grant_ch     currently/last granted channel
//   busy         scheduler is in GRANT
//
// Build option
//   GRANT_STATS_EN  adds one 16-bit saturating transfer counter per channel,
//                   read combinationally via stat_sel -> stat_cnt. Counters
//                   clear on reset. Without the macro these ports are absent.
// -----------------------------------------------------------------------------
module link_round_robin_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        cfg_ch_en,
    input  logic [3:0]               cfg_burst,
    output logic                     proc_valid,
    output logic [DATA_W-1:0]        proc_data,
    output logic [CH_W-1:0]          proc_ch,
    output logic                     proc_first,
    input  logic                     proc_taken,
    output logic [CH_W-1:0]          grant_ch,
`ifdef GRANT_STATS_EN
    input  logic [CH_W-1:0]          stat_sel,
    output logic [15:0]              stat_cnt,
`endif
    output logic                     busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [CH_W-1:0] rr_ptr;
    logic [3:0]      burst_cnt;

    // Round-robin search
    logic [NUM_CH-1:0] cand;
    logic              found;
    logic [CH_W-1:0]   hit;
    int unsigned       idx;
    logic [CH_W-1:0]   idx_c;

    always_comb begin
        cand  = req_valid & cfg_ch_en;
        found = 1'b0;
        hit   = '0;
        idx   = 0;
        idx_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_c = CH_W'(idx);
            if (!found && cand[idx_c]) begin
                found = 1'b1;
                hit   = idx_c;
            end
        end
    end

    // Granted-channel datapath
    logic              cur_req;
    logic              cur_en;
    logic              out_free;
    logic              accept;
    logic [3:0]        eff_burst;
    logic              last_word;
    logic              burst_end;
    logic [CH_W-1:0]   next_ptr;
    logic [DATA_W-1:0] cur_word;

    always_comb begin
        cur_req  = req_valid[grant_ch];
        cur_en   = cfg_ch_en[grant_ch];
        cur_word = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == grant_ch) begin
                cur_word = req_data[c*DATA_W +: DATA_W];
            end
        end

        // The output stage can take a word if it is empty or being drained
        // this same cycle; this is what makes back-to-back transfers possible.
        out_free = !proc_valid || proc_taken;
        accept   = (state == GRANT) && out_free && cur_req && cur_en;

        req_ready = '0;
        if (accept) begin
            req_ready[grant_ch] = 1'b1;
        end

        eff_burst = (cfg_burst == 4'd0) ? 4'd1 : cfg_burst;
        // >= rather than == so that lowering cfg_burst below the running
        // count mid-burst still closes the burst at the next accept.
        last_word = ({1'b0, burst_cnt} + 5'd1) >= {1'b0, eff_burst};

        burst_end = (accept && last_word)
                 || (out_free && !cur_req)
                 || !cur_en;

        next_ptr = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
    end

    // Scheduler FSM and registered output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            grant_ch   <= '0;
            busy       <= 1'b0;
            proc_valid <= 1'b0;
            proc_data  <= '0;
            proc_ch    <= '0;
            proc_first <= 1'b0;
        end else begin
            if (accept) begin
                proc_valid <= 1'b1;
                proc_data  <= cur_word;
                proc_ch    <= grant_ch;
                proc_first <= (burst_cnt == 4'd0);
            end else if (proc_taken) begin
                proc_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant_ch  <= hit;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                    if (burst_end) begin
                        rr_ptr <= next_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef GRANT_STATS_EN
    // Per-channel transfer counters
    logic [15:0] stat_mem [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                stat_mem[c] <= '0;
            end
        end else if (proc_valid && proc_taken) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (CH_W'(c) == proc_ch && stat_mem[c] != '1) begin
                    stat_mem[c] <= stat_mem[c] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == stat_sel) begin
                stat_cnt = stat_mem[c];
            end
        end
    end
`endif

endmodule

// File: tb/tb_link_round_robin_scheduler.sv
// -----------------------------------------------------------------------------
// tb_link_round_robin_scheduler
//
// Directed bench for link_round_robin_scheduler. Each channel is fed from a
// small word list; a word is removed from its list when req_ready was high at
// the edge. Transfers (proc_valid & proc_taken) are logged with their cycle
// number and compared against hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_link_round_robin_scheduler;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        cfg_ch_en;
    logic [3:0]               cfg_burst;
    logic                     proc_valid;
    logic [DATA_W-1:0]        proc_data;
    logic [CH_W-1:0]          proc_ch;
    logic                     proc_first;
    logic                     proc_taken;
    logic [CH_W-1:0]          grant_ch;
    logic                     busy;
`ifdef GRANT_STATS_EN
    logic [CH_W-1:0]          stat_sel;
    logic [15:0]              stat_cnt;
`endif

    always #5 clk = ~clk;

    link_round_robin_scheduler #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cfg_ch_en  (cfg_ch_en),
        .cfg_burst  (cfg_burst),
        .proc_valid (proc_valid),
        .proc_data  (proc_data),
        .proc_ch    (proc_ch),
        .proc_first (proc_first),
        .proc_taken (proc_taken),
        .grant_ch   (grant_ch),
`ifdef GRANT_STATS_EN
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt),
`endif
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;

    logic [63:0] src [NUM_CH][16];
    int          head [NUM_CH];
    int          tail [NUM_CH];

    logic [63:0] log_data  [64];
    int          log_ch    [64];
    logic        log_first [64];
    int          log_cyc   [64];
    int          log_n;
    int          cyc;

    logic [NUM_CH-1:0] last_rdy;
    logic [NUM_CH-1:0] rdy_seen;
    logic              multi_rdy = 1'b0;

    int e2_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int e2_k  [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
    int e4_ch [4]  = '{1, 3, 1, 3};
    int e4_k  [4]  = '{0, 0, 1, 1};
    int e5_ch [4]  = '{0, 3, 3, 3};
    int e5_k  [4]  = '{0, 1, 2, 3};

    function automatic logic [63:0] mkw(input int c, input int k);
        return {32'hC0DE0000 + 32'(c), 32'hBEEF0000 + 32'(k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [63:0] w);
        src[c][tail[c]] = w;
        tail[c]++;
    endtask

    // One clock: present source words at negedge, note handshakes, pop and
    // log after the rising edge.
    task automatic tick();
        logic        xv;
        logic [63:0] xd;
        int          xc;
        logic        xf;
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            req_valid[c] = (head[c] != tail[c]);
            req_data[c*DATA_W +: DATA_W] = (head[c] < 16) ? src[c][head[c]] : 64'd0;
        end
        #1;
        last_rdy = req_ready;
        if ($countones(req_ready) > 1) multi_rdy = 1'b1;
        rdy_seen = rdy_seen | req_ready;
        xv = proc_valid & proc_taken;
        xd = proc_data;
        xc = int'(proc_ch);
        xf = proc_first;
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (last_rdy[c]) head[c]++;
        end
        if (xv && log_n < 64) begin
            log_data[log_n]  = xd;
            log_ch[log_n]    = xc;
            log_first[log_n] = xf;
            log_cyc[log_n]   = cyc;
            log_n++;
        end
        cyc++;
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin
            head[c] = 0;
            tail[c] = 0;
        end
        log_n    = 0;
        cyc      = 0;
        rdy_seen = '0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        proc_taken = 1'b0;
        cfg_ch_en  = '1;
        cfg_burst  = 4'd1;
`ifdef GRANT_STATS_EN
        stat_sel   = '0;
`endif
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        int t;
        t = 0;
        while (log_n < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_proc_valid", proc_valid, 1'b0);
        check("rst_proc_data",  proc_data,  64'd0);
        check("rst_proc_ch",    proc_ch,    2'd0);
        check("rst_proc_first", proc_first, 1'b0);
        check("rst_grant_ch",   grant_ch,   2'd0);
        check("rst_busy",       busy,       1'b0);
        check("rst_req_ready",  req_ready,  4'b0000);

        // ---------------- single channel, 1-cycle latency ----------------
        do_reset();
        cfg_burst  = 4'd4;
        proc_taken = 1'b1;
        push(1, 64'h1111_1111_1111_1101);
        push(1, 64'h2222_2222_2222_2202);
        push(1, 64'h3333_3333_3333_3303);
        tick();
        check("t1_idle_rdy",  last_rdy,   4'b0000);
        check("t1_busy",      busy,       1'b1);
        check("t1_grant",     grant_ch,   2'd1);
        check("t1_pv_bubble", proc_valid, 1'b0);
        tick();
        check("t1_rdy_w0",    last_rdy,   4'b0010);
        check("t1_pv_w0",     proc_valid, 1'b1);
        check("t1_data_w0",   proc_data,  64'h1111_1111_1111_1101);
        check("t1_ch_w0",     proc_ch,    2'd1);
        check("t1_first_w0",  proc_first, 1'b1);
        tick();
        check("t1_data_w1",   proc_data,  64'h2222_2222_2222_2202);
        check("t1_first_w1",  proc_first, 1'b0);
        tick();
        check("t1_data_w2",   proc_data,  64'h3333_3333_3333_3303);
        check("t1_first_w2",  proc_first, 1'b0);
        check("t1_busy_mid",  busy,       1'b1);
        tick();
        check("t1_pv_end",    proc_valid, 1'b0);
        check("t1_busy_end",  busy,       1'b0);
        check("t1_count",     log_n,      3);
        check("t1_log_w0",    log_data[0], 64'h1111_1111_1111_1101);
        check("t1_log_w2",    log_data[2], 64'h3333_3333_3333_3303);
        check("t1_span",      log_cyc[2] - log_cyc[0], 2);

        // ---------------- four channels, burst 2 ----------------
        do_reset();
        cfg_burst  = 4'd2;
        proc_taken = 1'b1;
        for (int k = 0; k < 4; k++) push(0, mkw(0, k));
        for (int c = 1; c < NUM_CH; c++) begin
            for (int k = 0; k < 2; k++) push(c, mkw(c, k));
        end
        drain(10, 60);
        check("t2_count", log_n, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_ch_%0d", i),    log_ch[i],    e2_ch[i]);
            check($sformatf("t2_data_%0d", i),  log_data[i],  mkw(e2_ch[i], e2_k[i]));
            check($sformatf("t2_first_%0d", i), log_first[i], (i % 2) == 0);
            if (i > 0) begin
                check($sformatf("t2_gap_%0d", i), log_cyc[i] - log_cyc[i-1], (i % 2 == 1) ? 1 : 2);
            end
        end

        // ---------------- backpressure ----------------
        do_reset();
        cfg_burst  = 4'd8;
        proc_taken = 1'b1;
        for (int k = 0; k < 6; k++) push(2, mkw(2, k));
        tick();
        tick();
        tick();
        check("t3_pre_stall", proc_data, mkw(2, 1));
        proc_taken = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("t3_stall_rdy_%0d", s),  last_rdy,   4'b0000);
            check($sformatf("t3_stall_pv_%0d", s),   proc_valid, 1'b1);
            check($sformatf("t3_stall_data_%0d", s), proc_data,  mkw(2, 1));
        end
        proc_taken = 1'b1;
        drain(6, 40);
        check("t3_count", log_n, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_data_%0d", i),  log_data[i],  mkw(2, i));
            check($sformatf("t3_first_%0d", i), log_first[i], i == 0);
        end
        check("t3_stall_gap", log_cyc[1] - log_cyc[0], 6);

        // ---------------- enable mask, burst 0 ----------------
        do_reset();
        cfg_ch_en  = 4'b1010;
        cfg_burst  = 4'd0;
        proc_taken = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 2; k++) push(c, mkw(c, k));
        end
        drain(4, 40);
        check("t4_count", log_n, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_ch_%0d", i),    log_ch[i],    e4_ch[i]);
            check($sformatf("t4_data_%0d", i),  log_data[i],  mkw(e4_ch[i], e4_k[i]));
            check($sformatf("t4_first_%0d", i), log_first[i], 1'b1);
        end
        check("t4_masked_rdy", rdy_seen & 4'b0101, 4'b0000);

        // ---------------- reset mid-burst ----------------
        do_reset();
        cfg_burst  = 4'd4;
        proc_taken = 1'b1;
        for (int k = 0; k < 4; k++) push(3, mkw(3, k));
        tick();
        tick();
        check("t5_held_w0", proc_data, mkw(3, 0));
        proc_taken = 1'b0;
        tick();
        check("t5_hold_rdy", last_rdy, 4'b0000);
        push(0, mkw(0, 0));
        reset = 1'b1;
        #1;
        check("t5_rst_pv",    proc_valid, 1'b0);
        check("t5_rst_data",  proc_data,  64'd0);
        check("t5_rst_busy",  busy,       1'b0);
        check("t5_rst_grant", grant_ch,   2'd0);
        check("t5_rst_rdy",   req_ready,  4'b0000);
        @(posedge clk);
        #1;
        check("t5_rst_edge_pv", proc_valid, 1'b0);
        reset      = 1'b0;
        proc_taken = 1'b1;
        log_n      = 0;
        cyc        = 0;
        check("t5_ch3_consumed", head[3], 1);
        tick();
        check("t5_restart_grant", grant_ch, 2'd0);
        check("t5_restart_busy",  busy,     1'b1);
        drain(4, 40);
        check("t5_count", log_n, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_ch_%0d", i),    log_ch[i],    e5_ch[i]);
            check($sformatf("t5_data_%0d", i),  log_data[i],  mkw(e5_ch[i], e5_k[i]));
            check($sformatf("t5_first_%0d", i), log_first[i], i < 2);
        end

`ifdef GRANT_STATS_EN
        // ---------------- transfer counters ----------------
        do_reset();
        cfg_burst  = 4'd15;
        proc_taken = 1'b1;
        for (int k = 0; k < 10; k++) push(2, mkw(2, k));
        for (int t = 0; t < 40 && log_n < 10; t++) begin
            proc_taken = !(t == 4 || t == 7 || t == 9);
            tick();
        end
        proc_taken = 1'b0;
        check("t6_count", log_n, 10);
        for (int s = 0; s < NUM_CH; s++) begin
            stat_sel = CH_W'(s);
            #1;
            check($sformatf("t6_stat_%0d", s), stat_cnt, (s == 2) ? 16'd10 : 16'd0);
        end
`endif

        check("onehot_ready", multi_rdy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
